pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard and stall controller for the five-stage pipelined ARM datapath (F/D/E/M/W). It generates the forwarding selects, stall and flush strobes for every pipeline register. Beyond the basic load-use/branch hazard logic it adds three things: a multi-cycle data-memory wait-state FSM that freezes F–M, suppression of forwarding for the PC register, and saturating stall/flush performance counters. It sits beside the datapath and is driven by the controller's per-stage control bits.

## Interface
Parameters:
- ADDR_W, 4, register address width
- PC_REG, 15, register index that reads as PC; never forwarded
- MEM_WAIT, 0, extra cycles each data-memory access holds stage M (0 = single-cycle memory)
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- RA1D, RA2D  in  ADDR_W  decode-stage source registers
- RA1E, RA2E  in  ADDR_W  execute-stage source registers
- WA3E, WA3M, WA3W  in  ADDR_W  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  register write enable per stage
- MemtoRegE  in  1  instruction in E is a load
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction in that stage writes PC via ResultW
- BranchTakenE  in  1  branch resolved taken in E
- MemReqM  in  1  load/store in M
- cnt_clr  in  1  synchronous clear of both counters
- ForwardAE, ForwardBE  out  2  00 register file, 01 ResultW, 10 ALUOutM
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  bubble into pipeline register
- MemBusy  out  1  wait FSM in WAIT
- stall_cycles, flush_events  out  CNT_W  performance counters

## Operation
- Forwarding, source A (B identical with RA2E):
  - 10 if RegWriteM and RA1E==WA3M and RA1E!=PC_REG.
  - Otherwise 01 if RegWriteW and RA1E==WA3W and RA1E!=PC_REG.
  - Otherwise 00.
  - M has priority over W.
- Load-use: ldstall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
- PC pending: pcpend = PCSrcD | PCSrcE | PCSrcM.
- memstall (see FSM).
- Strobes:
  - StallF = memstall | ldstall | pcpend
  - StallD = memstall | ldstall
  - StallE = StallM = memstall
  - FlushD = ~memstall & (pcpend | PCSrcW | BranchTakenE)
  - FlushE = ~memstall & (ldstall | BranchTakenE)
  - FlushW = memstall
- memstall suppresses every D/E flush. A frozen branch or load re-evaluates the cycle the freeze lifts.
- Wait FSM, states IDLE and WAIT, with a down-counter wcnt of width clog2(MEM_WAIT+1):
  - IDLE: memstall = MemReqM & (MEM_WAIT!=0). On that condition wcnt <= MEM_WAIT-1 and go to WAIT.
  - WAIT: memstall = (wcnt!=0). If wcnt!=0, decrement. If wcnt==0, return to IDLE; MemReqM is not sampled on this cycle, so the same access cannot retrigger.
  - With MEM_WAIT=0 the FSM never leaves IDLE.
- Counters:
  - stall_cycles increments on every cycle with StallF=1.
  - flush_events increments on every cycle with FlushE=1.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and FSM state; they are valid in the same cycle.
- MemBusy and the counters are registered.
- Reset (asynchronous) sets state IDLE, wcnt 0 and counters 0. While reset is high, all stall/flush outputs are forced to 0, Forward* to 00 and MemBusy to 0.
- Reset asserted mid-WAIT aborts the access. The FSM restarts in IDLE after release.
- A memory access in M holds F–M for exactly MEM_WAIT cycles and advances at the end of cycle MEM_WAIT+1.
- Back-to-back memory instructions each incur the full MEM_WAIT.
- Counters update on the clock edge after the counted cycle. Saturated value holds.

## Test plan
- Forwarding: RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Set RA1E=WA3M=15 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle.
- Branch: BranchTakenE=1 -> FlushD=FlushE=1. PCSrcD=1 -> StallF=FlushD=1, FlushE=0.
- Wait states, MEM_WAIT=2: MemReqM held 3 cycles -> Stall F/D/E/M and FlushW high for cycles 0–1, low in cycle 2; MemBusy high in cycles 1–2. A BranchTakenE during cycles 0–1 gives FlushD=FlushE=0.
- Counters, CNT_W=2: StallF high 5 cycles -> stall_cycles 1,2,3,3,3. cnt_clr -> 0 next edge.
- Asynchronous reset mid-WAIT -> MemBusy=0 and counters 0 immediately. The next MemReqM restarts the full MEM_WAIT.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the F/D/E/M/W ARM pipeline: forwarding selects,
// stall/flush strobes, a data-memory wait-state FSM and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int PC_REG   = 15,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] RA1E,
    input  logic [ADDR_W-1:0] RA2E,
    input  logic [ADDR_W-1:0] WA3E,
    input  logic [ADDR_W-1:0] WA3M,
    input  logic [ADDR_W-1:0] WA3W,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              PCSrcD,
    input  logic              PCSrcE,
    input  logic              PCSrcM,
    input  logic              PCSrcW,
    input  logic              BranchTakenE,
    input  logic              MemReqM,
    input  logic              cnt_clr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemBusy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam int                WCNT_W    = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LOAD = (MEM_WAIT > 0) ? WCNT_W'(MEM_WAIT - 1) : '0;
    localparam logic              MEM_EN    = (MEM_WAIT != 0);
    localparam logic [ADDR_W-1:0] PC_ADDR   = ADDR_W'(PC_REG);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_events_q, flush_events_d;
    logic              memstall, ldstall, pcpend;
    logic [1:0]        fwd_a, fwd_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wcnt_q         <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // The final WAIT cycle ignores MemReqM so a held access cannot retrigger itself.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (MemReqM && MEM_EN) begin
                    wcnt_d  = WCNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q != '0) wcnt_d = wcnt_q - WCNT_W'(1);
                else              state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        memstall = (state_q == ST_IDLE) ? (MemReqM & MEM_EN) : (wcnt_q != '0);
        ldstall  = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
        pcpend   = PCSrcD | PCSrcE | PCSrcM;

        fwd_a = 2'b00;
        if (RegWriteM && RA1E == WA3M && RA1E != PC_ADDR)      fwd_a = 2'b10;
        else if (RegWriteW && RA1E == WA3W && RA1E != PC_ADDR) fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (RegWriteM && RA2E == WA3M && RA2E != PC_ADDR)      fwd_b = 2'b10;
        else if (RegWriteW && RA2E == WA3W && RA2E != PC_ADDR) fwd_b = 2'b01;

        ForwardAE = reset ? 2'b00 : fwd_a;
        ForwardBE = reset ? 2'b00 : fwd_b;
        StallF    = ~reset & (memstall | ldstall | pcpend);
        StallD    = ~reset & (memstall | ldstall);
        StallE    = ~reset & memstall;
        StallM    = ~reset & memstall;
        FlushD    = ~reset & ~memstall & (pcpend | PCSrcW | BranchTakenE);
        FlushE    = ~reset & ~memstall & (ldstall | BranchTakenE);
        FlushW    = ~reset & memstall;
        MemBusy   = (state_q == ST_WAIT);
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (cnt_clr) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end else begin
            if (StallF && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
            if (FlushE && flush_events_q != '1) flush_events_d = flush_events_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with MEM_WAIT=2 and 2-bit counters.
module tb_pipeline_hazard_ctrl;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 2;

    logic clk = 1'b0;
    logic reset;
    logic [ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, cnt_clr;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;
    logic [11:0]        exp_q[$];
    logic [2*CNT_W-1:0] cnt_exp_q[$];
    logic [11:0]        exp_v;
    logic [2*CNT_W-1:0] cnt_exp_v;
    wire  [11:0]        obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                               FlushD, FlushE, FlushW, MemBusy};
    wire  [2*CNT_W-1:0] cnt_obs = {stall_cycles, flush_events};

    pipeline_hazard_ctrl #(
        .ADDR_W(ADDR_W), .PC_REG(15), .MEM_WAIT(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .cnt_clr(cnt_clr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemBusy(MemBusy),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    // {ForwardAE, ForwardBE, StallF/D/E/M, FlushD/E/W, MemBusy}
    function automatic logic [11:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [3:0] st, input logic [2:0] fl,
                                       input logic mb);
        return {fa, fb, st, fl, mb};
    endfunction

    task automatic clear_inputs();
        RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
        WA3E = 4'd1; WA3M = 4'd1; WA3W = 4'd1;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
        BranchTakenE = 0; MemReqM = 0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        RegWriteM = 1; WA3M = 4'd3; RA1E = 4'd3; PCSrcD = 1; MemReqM = 1; BranchTakenE = 1;
        exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
        cnt_exp_q.push_back('0);
        #3;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", obs, exp_v);
        end
        cnt_exp_v = cnt_exp_q.pop_front();
        checks++;
        if (cnt_obs !== cnt_exp_v) begin
            errors++;
            $display("FAIL reset_counters: got %h required %h", cnt_obs, cnt_exp_v);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    RegWriteM = 1; WA3M = 4'd3; RegWriteW = 1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
                    exp_q.push_back(pk(2'b10, 2'b10, 4'b0000, 3'b000, 1'b0));
                end
                1: begin
                    RegWriteM = 0; WA3M = 4'd3; RegWriteW = 1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd3;
                    exp_q.push_back(pk(2'b01, 2'b01, 4'b0000, 3'b000, 1'b0));
                end
                2: begin
                    RegWriteM = 1; WA3M = 4'd15; RegWriteW = 1; WA3W = 4'd3; RA1E = 4'd15; RA2E = 4'd3;
                    exp_q.push_back(pk(2'b00, 2'b01, 4'b0000, 3'b000, 1'b0));
                end
                default: begin
                    RegWriteM = 1; WA3M = 4'd7; RegWriteW = 1; WA3W = 4'd15; RA1E = 4'd15; RA2E = 4'd7;
                    exp_q.push_back(pk(2'b00, 2'b10, 4'b0000, 3'b000, 1'b0));
                end
            endcase
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL forwarding_%0d: got %h required %h", i, obs, exp_v);
            end
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            MemtoRegE = (i != 3); RegWriteE = 1; WA3E = 4'd5;
            case (i)
                0: begin RA2D = 4'd5; exp_q.push_back(pk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0)); end
                1: begin RA1D = 4'd5; exp_q.push_back(pk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0)); end
                2: begin RA1D = 4'd4; RA2D = 4'd6; exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0)); end
                default: begin RA2D = 4'd5; exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0)); end
            endcase
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_use_%0d: got %h required %h", i, obs, exp_v);
            end
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            case (i)
                0: begin BranchTakenE = 1; exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0)); end
                1: begin PCSrcD = 1;       exp_q.push_back(pk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0)); end
                2: begin PCSrcE = 1;       exp_q.push_back(pk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0)); end
                3: begin PCSrcM = 1;       exp_q.push_back(pk(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0)); end
                default: begin PCSrcW = 1; exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b100, 1'b0)); end
            endcase
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL branch_%0d: got %h required %h", i, obs, exp_v);
            end
        end
        clear_inputs();
    endtask

    // Drives MemReqM/BranchTakenE from bit patterns, one bit per cycle, checking at negedge.
    task automatic run_mem_cycles(input string name, input int n, input logic [7:0] req,
                                  input logic [7:0] br);
        @(posedge clk);
        #1;
        for (int c = 0; c < n; c++) begin
            MemReqM = req[c];
            BranchTakenE = br[c];
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s_cycle%0d: got %h required %h", name, c, obs, exp_v);
            end
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    task automatic test_wait_states();
        clear_inputs();
        exp_q.push_back(pk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
        exp_q.push_back(pk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1));
        exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b1));
        exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
        run_mem_cycles("wait_states", 4, 8'b0000_0111, 8'b0000_0111);
    endtask

    task automatic test_back_to_back();
        logic [6:0] st_pat = 7'b0011011;
        logic [6:0] mb_pat = 7'b0110110;
        clear_inputs();
        for (int c = 0; c < 7; c++)
            exp_q.push_back(pk(2'b00, 2'b00, {4{st_pat[c]}}, {2'b00, st_pat[c]}, mb_pat[c]));
        run_mem_cycles("back_to_back", 7, 8'b0011_1111, 8'b0000_0000);
    endtask

    task automatic test_counters();
        logic [CNT_W-1:0] st_exp[10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
        logic [CNT_W-1:0] fl_exp[10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        @(posedge clk);
        #1;
        for (int s = 0; s < 10; s++) begin
            clear_inputs();
            cnt_clr      = (s == 0) || (s == 8);
            PCSrcD       = (s >= 1 && s <= 5) || (s >= 8);
            BranchTakenE = (s >= 6);
            cnt_exp_q.push_back({st_exp[s], fl_exp[s]});
            @(posedge clk);
            #1;
            cnt_exp_v = cnt_exp_q.pop_front();
            checks++;
            if (cnt_obs !== cnt_exp_v) begin
                errors++;
                $display("FAIL counters_step%0d: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                         s, stall_cycles, flush_events, cnt_exp_v[2*CNT_W-1:CNT_W], cnt_exp_v[CNT_W-1:0]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        @(posedge clk);
        #1;
        MemReqM = 1;
        @(posedge clk);
        #1;
        exp_q.push_back(pk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1));
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL pre_reset_wait: got %h required %h", obs, exp_v);
        end
        RegWriteM = 1; WA3M = 4'd3; RA1E = 4'd3; PCSrcD = 1;
        reset = 1'b1;
        exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
        cnt_exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mid_wait_reset_outputs: got %h required %h", obs, exp_v);
        end
        cnt_exp_v = cnt_exp_q.pop_front();
        checks++;
        if (cnt_obs !== cnt_exp_v) begin
            errors++;
            $display("FAIL mid_wait_reset_counters: got %h required %h", cnt_obs, cnt_exp_v);
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        exp_q.push_back(pk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
        exp_q.push_back(pk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1));
        exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b1));
        exp_q.push_back(pk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
        run_mem_cycles("restart_after_reset", 4, 8'b0000_0111, 8'b0000_0000);
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_wait_states();
        test_back_to_back();
        test_counters();
        test_reset_mid_wait();
        if (exp_q.size() != 0 || cnt_exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0",
                     exp_q.size() + cnt_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
